mastermind_scorer: RTL and testbench

Scoring stage directly downstream of the Mastermind control FSM and code/guess registers. It takes the latched 12-bit secret code and the 12-bit guess, and counts exact matches (black pegs) and right-colour-wrong-position matches (white pegs) in a fixed multi-cycle sequence. It also tracks the number of guesses, detects a win, and flags game over, so the HEX display stage can show results.

---
 rtl/mastermind_scorer_if.sv | 25 ++
 rtl/mastermind_scorer.sv | 150 +++++++++++++++
 tb/tb_mastermind_scorer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mastermind_scorer_if.sv
// Handshake and result bundle between the game controller and the
// Mastermind scorer.
interface mastermind_scorer_if;
    logic [11:0] code;
    logic [11:0] guess;
    logic        start;
    logic        new_game;
    logic        busy;
    logic        done;
    logic [2:0]  black;
    logic [2:0]  white;
    logic [3:0]  attempts;
    logic        win;
    logic        game_over;

    modport master (
        output code, guess, start, new_game,
        input  busy, done, black, white, attempts, win, game_over
    );

    modport slave (
        input  code, guess, start, new_game,
        output busy, done, black, white, attempts, win, game_over
    );
endinterface

// File: rtl/mastermind_scorer.sv
// Multi-cycle Mastermind scorer: 4 cycles of exact-position compare, 8 cycles
// of per-colour min-count accumulation, then one DONE cycle updating results.
module mastermind_scorer #(
    parameter int MAX_GUESSES = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    mastermind_scorer_if.slave    bus
);
    localparam logic [3:0] MAX_G = 4'(MAX_GUESSES);

    typedef enum logic [1:0] {IDLE, EXACT, COLOUR, DONE} state_e;

    state_e      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [11:0] code_q, code_d;
    logic [11:0] guess_q, guess_d;
    logic [2:0]  black_acc_q, black_acc_d;
    logic [3:0]  total_q, total_d;
    logic [2:0]  black_q, black_d;
    logic [2:0]  white_q, white_d;
    logic [3:0]  attempts_q, attempts_d;
    logic        win_q, win_d;
    logic        game_over_q, game_over_d;

    logic [3:0]  exact_vec;
    logic [3:0]  code_hit;
    logic [3:0]  guess_hit;
    logic [2:0]  code_cnt;
    logic [2:0]  guess_cnt;
    logic [2:0]  min_cnt;
    logic [3:0]  white_diff;

    // Per-peg comparators: exact match, and colour idx present in code/guess.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_peg
            assign exact_vec[gi] = (code_q[3*gi +: 3] == guess_q[3*gi +: 3]);
            assign code_hit[gi]  = (code_q[3*gi +: 3] == idx_q);
            assign guess_hit[gi] = (guess_q[3*gi +: 3] == idx_q);
        end
    endgenerate

    assign code_cnt   = {2'b0, code_hit[0]} + {2'b0, code_hit[1]}
                      + {2'b0, code_hit[2]} + {2'b0, code_hit[3]};
    assign guess_cnt  = {2'b0, guess_hit[0]} + {2'b0, guess_hit[1]}
                      + {2'b0, guess_hit[2]} + {2'b0, guess_hit[3]};
    assign min_cnt    = (code_cnt < guess_cnt) ? code_cnt : guess_cnt;
    assign white_diff = total_q - {1'b0, black_acc_q};

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        code_d      = code_q;
        guess_d     = guess_q;
        black_acc_d = black_acc_q;
        total_d     = total_q;
        black_d     = black_q;
        white_d     = white_q;
        attempts_d  = attempts_q;
        win_d       = win_q;
        game_over_d = game_over_q;

        case (state_q)
            IDLE: begin
                if (bus.start && !game_over_q) begin
                    code_d      = bus.code;
                    guess_d     = bus.guess;
                    black_acc_d = '0;
                    total_d     = '0;
                    idx_d       = '0;
                    state_d     = EXACT;
                end
            end
            EXACT: begin
                if (exact_vec[idx_q[1:0]]) begin
                    black_acc_d = black_acc_q + 3'd1;
                end
                if (idx_q == 3'd3) begin
                    idx_d   = '0;
                    state_d = COLOUR;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            COLOUR: begin
                total_d = total_q + {1'b0, min_cnt};
                idx_d   = idx_q + 3'd1;
                if (idx_q == 3'd7) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                black_d     = black_acc_q;
                white_d     = white_diff[2:0];
                attempts_d  = attempts_q + 4'd1;
                win_d       = (black_acc_q == 3'd4);
                game_over_d = (black_acc_q == 3'd4) || (attempts_q + 4'd1 == MAX_G);
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // new_game aborts any run and wins over a simultaneous start.
        if (bus.new_game) begin
            state_d     = IDLE;
            attempts_d  = '0;
            black_d     = '0;
            white_d     = '0;
            win_d       = 1'b0;
            game_over_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            code_q      <= '0;
            guess_q     <= '0;
            black_acc_q <= '0;
            total_q     <= '0;
            black_q     <= '0;
            white_q     <= '0;
            attempts_q  <= '0;
            win_q       <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            code_q      <= code_d;
            guess_q     <= guess_d;
            black_acc_q <= black_acc_d;
            total_q     <= total_d;
            black_q     <= black_d;
            white_q     <= white_d;
            attempts_q  <= attempts_d;
            win_q       <= win_d;
            game_over_q <= game_over_d;
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.black     = black_q;
    assign bus.white     = white_q;
    assign bus.attempts  = attempts_q;
    assign bus.win       = win_q;
    assign bus.game_over = game_over_q;
endmodule

// File: tb/tb_mastermind_scorer.sv
// Scoreboard bench for mastermind_scorer: expected scores are queued at start
// and compared in the cycle after each done pulse.
module tb_mastermind_scorer;
    localparam int MAXG = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;

    mastermind_scorer_if bus ();

    mastermind_scorer #(.MAX_GUESSES(MAXG)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] black;
        logic [2:0] white;
        logic [3:0] attempts;
        logic       win;
        logic       game_over;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    logic pending = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   mdl_attempts = 0;
    logic mdl_go = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic logic [11:0] pack(input int a, input int b, input int c, input int d);
        logic [11:0] r;
        r = {3'(d), 3'(c), 3'(b), 3'(a)};
        return r;
    endfunction

    // Classic peg-marking scorer: exact pegs first, then pair remaining pegs.
    function automatic void score(input logic [11:0] c, input logic [11:0] g,
                                  output int b, output int w);
        bit cu[4];
        bit gu[4];
        b = 0;
        w = 0;
        for (int i = 0; i < 4; i++) begin
            cu[i] = 1'b0;
            gu[i] = 1'b0;
            if (c[3*i +: 3] == g[3*i +: 3]) begin
                b++;
                cu[i] = 1'b1;
                gu[i] = 1'b1;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (!gu[i]) begin
                for (int j = 0; j < 4; j++) begin
                    if (!cu[j] && !gu[i] && g[3*i +: 3] == c[3*j +: 3]) begin
                        w++;
                        cu[j] = 1'b1;
                        gu[i] = 1'b1;
                    end
                end
            end
        end
    endfunction

    always @(negedge clk) begin
        if (pending) begin
            pending = 1'b0;
            $display("scored: black=%0d white=%0d attempts=%0d win=%0d game_over=%0d",
                     bus.black, bus.white, bus.attempts, bus.win, bus.game_over);
            check_val("black", 32'(bus.black), 32'(cur.black));
            check_val("white", 32'(bus.white), 32'(cur.white));
            check_val("attempts", 32'(bus.attempts), 32'(cur.attempts));
            check_val("win", 32'(bus.win), 32'(cur.win));
            check_val("game_over", 32'(bus.game_over), 32'(cur.game_over));
        end
        if (bus.done) begin
            done_cnt++;
            if (sb.size() > 0) begin
                cur = sb.pop_front();
                pending = 1'b1;
            end else begin
                check_val("unexpected_done", 32'(bus.done), 32'd0);
            end
        end
    end

    task automatic model_clear();
        mdl_attempts = 0;
        mdl_go = 1'b0;
        sb.delete();
    endtask

    task automatic do_new_game();
        bus.new_game = 1'b1;
        @(posedge clk); #1;
        bus.new_game = 1'b0;
        model_clear();
        check_val("ng_attempts", 32'(bus.attempts), 32'd0);
        check_val("ng_game_over", 32'(bus.game_over), 32'd0);
        check_val("ng_win", 32'(bus.win), 32'd0);
        check_val("ng_black", 32'(bus.black), 32'd0);
        check_val("ng_busy", 32'(bus.busy), 32'd0);
    endtask

    // mode: 0 normal, 1 corrupt guess at cycle 3 + stray start at cycle 5,
    //       2 new_game at cycle 7, 3 reset at cycle 6
    task automatic run(input logic [11:0] c, input logic [11:0] g, input int mode);
        exp_t e;
        int   b, w, cyc, dc0;
        logic accepted;
        accepted = !mdl_go;
        dc0 = done_cnt;
        bus.code  = c;
        bus.guess = g;
        bus.start = 1'b1;
        if (accepted) begin
            score(c, g, b, w);
            mdl_attempts++;
            e.black     = 3'(b);
            e.white     = 3'(w);
            e.attempts  = 4'(mdl_attempts);
            e.win       = (b == 4);
            e.game_over = (b == 4) || (mdl_attempts == MAXG);
            mdl_go      = e.game_over;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 1;
        if (!accepted) begin
            check_val("ignored_busy", 32'(bus.busy), 32'd0);
            check_val("ignored_attempts", 32'(bus.attempts), 32'(mdl_attempts));
            return;
        end
        check_val("busy_after_start", 32'(bus.busy), 32'd1);
        while (!bus.done && cyc < 40) begin
            if (mode == 1 && cyc == 3) bus.guess = 12'h000;
            if (mode == 1 && cyc == 5) bus.start = 1'b1;
            if (mode == 2 && cyc == 7) bus.new_game = 1'b1;
            if (mode == 3 && cyc == 6) reset = 1'b1;
            @(posedge clk); #1;
            bus.start = 1'b0;
            cyc++;
            if (mode == 2 && cyc == 8) begin
                bus.new_game = 1'b0;
                model_clear();
                check_val("abort_busy", 32'(bus.busy), 32'd0);
                check_val("abort_attempts", 32'(bus.attempts), 32'd0);
                repeat (10) @(posedge clk);
                #1;
                check_val("abort_no_done", 32'(done_cnt - dc0), 32'd0);
                return;
            end
            if (mode == 3 && cyc == 7) begin
                reset = 1'b0;
                model_clear();
                check_val("rst_busy", 32'(bus.busy), 32'd0);
                check_val("rst_done", 32'(bus.done), 32'd0);
                check_val("rst_black", 32'(bus.black), 32'd0);
                check_val("rst_white", 32'(bus.white), 32'd0);
                check_val("rst_attempts", 32'(bus.attempts), 32'd0);
                check_val("rst_win", 32'(bus.win), 32'd0);
                check_val("rst_game_over", 32'(bus.game_over), 32'd0);
                return;
            end
        end
        check_val("done_cycle", 32'(cyc), 32'd13);
        check_val("busy_at_done", 32'(bus.busy), 32'd1);
        @(posedge clk); #1;
        check_val("busy_cycle14", 32'(bus.busy), 32'd0);
        if (mode == 1) begin
            repeat (20) @(posedge clk);
            #1;
            check_val("single_done", 32'(done_cnt - dc0), 32'd1);
        end
    endtask

    initial begin
        logic [11:0] code_v, guess_v;
        bus.code = '0;
        bus.guess = '0;
        bus.start = 1'b0;
        bus.new_game = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_busy", 32'(bus.busy), 32'd0);
        check_val("reset_done", 32'(bus.done), 32'd0);
        check_val("reset_attempts", 32'(bus.attempts), 32'd0);
        check_val("reset_game_over", 32'(bus.game_over), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        run(pack(1, 2, 3, 4), pack(1, 2, 3, 4), 0);
        run(pack(1, 2, 3, 4), pack(4, 3, 2, 1), 0);
        do_new_game();
        run(pack(0, 1, 2, 3), pack(4, 5, 6, 7), 0);
        do_new_game();
        run(pack(1, 2, 3, 4), pack(4, 3, 2, 1), 0);
        run(pack(1, 1, 2, 2), pack(1, 2, 1, 1), 1);
        do_new_game();

        code_v = pack(5, 0, 7, 2);
        for (int k = 0; k < MAXG; k++) begin
            guess_v = 12'($urandom_range(0, 4095));
            if (guess_v == code_v) guess_v = guess_v ^ 12'h001;
            run(code_v, guess_v, 0);
        end
        check_val("exh_attempts", 32'(bus.attempts), 32'(MAXG));
        check_val("exh_game_over", 32'(bus.game_over), 32'd1);
        run(code_v, pack(0, 0, 0, 0), 0);
        do_new_game();

        run(pack(3, 3, 6, 1), pack(3, 6, 1, 1), 2);
        run(pack(3, 3, 6, 1), pack(3, 6, 1, 1), 0);
        run(pack(7, 6, 5, 4), pack(7, 5, 6, 4), 3);
        run(pack(2, 2, 2, 2), pack(2, 0, 2, 0), 0);

        repeat (3) @(posedge clk);
        check_val("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
